vote_round_controller: RTL

//  Sequences one 5-way majority-vote round: opens a collection window, accepts one vote per voter via

---
 rtl/vote_pkg.sv | 6 +
 rtl/popcount5.sv | 13 +
 rtl/vote_round_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the 5-way vote round controller.
package vote_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;
   localparam int N_VOTERS = 5;
   localparam int PCNT_W   = 3;
endpackage

// File: rtl/popcount5.sv
// Population count of a 5-bit vector.
module popcount5
   import vote_pkg::*;
(
   input  logic [N_VOTERS-1:0] bits,
   output logic [PCNT_W-1:0]   count
);
   always_comb begin
      count = '0;
      for (int i = 0; i < N_VOTERS; i++)
         count = count + PCNT_W'(bits[i]);
   end
endmodule

// File: rtl/vote_round_controller.sv
// Runs one 5-way majority-vote round per start pulse and presents the decision
// through a valid/ready handshake; tracks per-voter dissent and flags persistent dissenters.
//
// state   | meaning
// IDLE    | waiting for start; res_* hold the last decision
// COLLECT | window open, one vote accepted per voter
// RESULT  | first cycle registers the decision, then res_valid until accepted
module vote_round_controller
   import vote_pkg::*;
#(
   parameter int TIMEOUT   = 16,
   parameter int QUORUM    = 3,
   parameter int DCNT_W    = 8,
   parameter int FAULT_LIM = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [N_VOTERS-1:0] vote_valid,
   input  logic [N_VOTERS-1:0] vote_bit,
   output logic [N_VOTERS-1:0] vote_ready,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_maj,
   output logic [PCNT_W-1:0]   res_count,
   output logic                res_quorum,
   output logic                busy,
   output logic [N_VOTERS-1:0] fault
);
   localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t              state;
   logic [N_VOTERS-1:0] recv;
   logic [N_VOTERS-1:0] vote;
   logic [TMR_W-1:0]    timer;
   logic [N_VOTERS-1:0] capture;
   logic [N_VOTERS-1:0] recv_nxt;
   logic [PCNT_W-1:0]   cnt_recv;
   logic [PCNT_W-1:0]   cnt_ones;
   logic                quorum_now;
   logic                maj_now;
   logic                handshake;

   assign vote_ready = (state == COLLECT) ? ~recv : '0;
   assign capture    = vote_valid & vote_ready;
   assign recv_nxt   = recv | capture;
   assign busy       = (state != IDLE);
   assign handshake  = (state == RESULT) && res_valid && res_ready;

   popcount5 u_cnt_recv (.bits(recv),        .count(cnt_recv));
   popcount5 u_cnt_ones (.bits(vote & recv), .count(cnt_ones));

   assign quorum_now = (cnt_recv >= PCNT_W'(QUORUM));
   // Strict majority of received votes; a tie resolves to 0.
   assign maj_now    = quorum_now && ({cnt_ones, 1'b0} > {1'b0, cnt_recv});

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         recv       <= '0;
         vote       <= '0;
         timer      <= '0;
         res_valid  <= 1'b0;
         res_maj    <= 1'b0;
         res_count  <= '0;
         res_quorum <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= COLLECT;
                  recv  <= '0;
                  vote  <= '0;
                  timer <= '0;
               end
            end
            COLLECT: begin
               recv  <= recv_nxt;
               vote  <= (vote & ~capture) | (vote_bit & capture);
               timer <= timer + 1'b1;
               if (recv_nxt == '1 || timer == TMR_W'(TIMEOUT - 1))
                  state <= RESULT;
            end
            RESULT: begin
               if (!res_valid) begin
                  res_valid  <= 1'b1;
                  res_count  <= cnt_recv;
                  res_quorum <= quorum_now;
                  res_maj    <= maj_now;
               end else if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < N_VOTERS; g++) begin : g_dissent
      logic [DCNT_W-1:0] dissent;

      always_ff @(posedge clk) begin
         if (rst)
            dissent <= '0;
         else if (handshake && res_quorum && recv[g] && (vote[g] != res_maj) && (dissent != '1))
            dissent <= dissent + 1'b1;
      end

      assign fault[g] = (dissent >= DCNT_W'(FAULT_LIM));
   end
endmodule
